idli_retire_sb: RTL and testbench

- Parametrised retirement monitor and register scoreboard for the idli bench wrappers.
- Replaces the ad-hoc done/scoreboard flops in the bench.
- Watches the core sync counter and execute-stage run/destination signals. Produces a registered instruction-done pulse, a clearable per-register write scoreboard, a wrapping retire counter, and a FIFO of retirement records the bench drains with a valid/ready handshake.
- Lives under test/ and is bound to the core hierarchy by the bench wrapper.

---
 rtl/idli_retire_sb.sv | 140 ++++++++++++++
 tb/tb_idli_retire_sb.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/idli_retire_sb.sv
// rtl/idli_retire_sb.sv - retirement monitor, register write scoreboard and retire-record FIFO
// Captures destination info at slot start and pushes it as a record when the slot retires.
module idli_retire_sb #(
  parameter int NUM_REGS = 16,
  parameter int CTR_W    = 2,
  parameter int DEPTH    = 8,
  parameter int CNT_W    = 32,
  localparam int REG_W   = $clog2(NUM_REGS),
  localparam int AW      = $clog2(DEPTH),
  localparam int REC_W   = REG_W + 1
) (
  input  logic                i_sb_gck,
  input  logic                i_sb_rst,
  input  logic [CTR_W-1:0]    i_sb_ctr,
  input  logic                i_sb_run_instr,
  input  logic                i_sb_dst_reg_vld,
  input  logic [REG_W-1:0]    i_sb_dst_reg,
  input  logic [NUM_REGS-1:0] i_sb_sb_clr,
  output logic                o_sb_done,
  output logic [NUM_REGS-1:0] o_sb_reg_sb,
  output logic [CNT_W-1:0]    o_sb_retire_cnt,
  output logic                o_sb_rec_vld,
  input  logic                i_sb_rec_rdy,
  output logic                o_sb_rec_wr,
  output logic [REG_W-1:0]    o_sb_rec_reg,
  output logic                o_sb_rec_ovf,
  input  logic                i_sb_ovf_clr
);

  logic                done_q, done_d;
  logic [NUM_REGS-1:0] reg_sb_q, reg_sb_d;
  logic [CNT_W-1:0]    retire_cnt_q, retire_cnt_d;
  logic                ovf_q, ovf_d;
  logic                cap_wr_q, cap_wr_d;
  logic [REG_W-1:0]    cap_reg_q, cap_reg_d;
  logic [AW:0]         wptr_q, wptr_d;
  logic [AW:0]         rptr_q, rptr_d;
  logic [REC_W-1:0]    mem_q [DEPTH];
  logic [REC_W-1:0]    mem_d [DEPTH];

  logic                slot_start;
  logic                retire;
  logic                fifo_empty;
  logic                fifo_full;
  logic                pop;
  logic                push;
  logic                drop;
  logic [NUM_REGS-1:0] set_mask;
  logic [REC_W-1:0]    head;

  assign slot_start = (i_sb_ctr == '0) && i_sb_run_instr;
  assign retire     = (&i_sb_ctr) && i_sb_run_instr;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign fifo_empty = (wptr_q == rptr_q);
  assign fifo_full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pop        = !fifo_empty && i_sb_rec_rdy;
  assign push       = retire && (!fifo_full || pop);
  assign drop       = retire && fifo_full && !pop;
  assign head       = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    set_mask = '0;
    if (slot_start && i_sb_dst_reg_vld) begin
      set_mask[i_sb_dst_reg] = 1'b1;
    end
  end

  always_comb begin
    done_d       = retire;
    // Clear is applied first so a same-cycle set survives.
    reg_sb_d     = (reg_sb_q & ~i_sb_sb_clr) | set_mask;
    retire_cnt_d = retire_cnt_q + {{(CNT_W-1){1'b0}}, retire};
    cap_wr_d     = cap_wr_q;
    cap_reg_d    = cap_reg_q;
    if (slot_start) begin
      cap_wr_d  = i_sb_dst_reg_vld;
      cap_reg_d = i_sb_dst_reg;
    end
    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (i_sb_ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (push) begin
      mem_d[wptr_q[AW-1:0]] = {cap_wr_q, cap_reg_q};
      wptr_d                = wptr_q + 1'b1;
    end
    if (pop) begin
      rptr_d = rptr_q + 1'b1;
    end
  end

  always_ff @(posedge i_sb_gck) begin
    if (i_sb_rst) begin
      done_q       <= 1'b0;
      reg_sb_q     <= '0;
      retire_cnt_q <= '0;
      ovf_q        <= 1'b0;
      cap_wr_q     <= 1'b0;
      cap_reg_q    <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
    end else begin
      done_q       <= done_d;
      reg_sb_q     <= reg_sb_d;
      retire_cnt_q <= retire_cnt_d;
      ovf_q        <= ovf_d;
      cap_wr_q     <= cap_wr_d;
      cap_reg_q    <= cap_reg_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
    end
  end

  // Storage needs no reset: reads are masked whenever the FIFO is empty.
  always_ff @(posedge i_sb_gck) begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

  assign o_sb_done       = done_q;
  assign o_sb_reg_sb     = reg_sb_q;
  assign o_sb_retire_cnt = retire_cnt_q;
  assign o_sb_rec_vld    = !fifo_empty;
  assign o_sb_rec_wr     = fifo_empty ? 1'b0 : head[REG_W];
  assign o_sb_rec_reg    = fifo_empty ? '0 : head[REG_W-1:0];
  assign o_sb_rec_ovf    = ovf_q;

endmodule

// File: tb/tb_idli_retire_sb.sv
// tb/tb_idli_retire_sb.sv - directed, table-driven bench for idli_retire_sb
// Slots are driven phase by phase; a small FIFO/scoreboard model tracks expected state.
module tb_idli_retire_sb;

  localparam int NUM_REGS = 16;
  localparam int CTR_W    = 2;
  localparam int DEPTH    = 8;
  localparam int CNT_W    = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  ctr;
  logic        run;
  logic        dvld;
  logic [3:0]  dreg;
  logic [15:0] sb_clr;
  logic        done;
  logic [15:0] reg_sb;
  logic [3:0]  cnt;
  logic        rec_vld;
  logic        rec_rdy;
  logic        rec_wr;
  logic [3:0]  rec_reg;
  logic        ovf;
  logic        ovf_clr;

  int errors = 0;
  int checks = 0;

  logic [4:0]  mdl_q[$];
  logic [15:0] m_sb;
  logic [3:0]  m_cnt;
  logic        m_ovf;
  logic [4:0]  m_cap;

  typedef struct {
    logic        run;
    logic        vld;
    logic [3:0]  rg;
    logic [15:0] exp_sb;
    logic [3:0]  exp_cnt;
    logic [4:0]  exp_rec;
  } vec_t;

  vec_t t1[3];
  vec_t t2[4];

  always #5 clk = ~clk;

  idli_retire_sb #(
    .NUM_REGS(NUM_REGS),
    .CTR_W   (CTR_W),
    .DEPTH   (DEPTH),
    .CNT_W   (CNT_W)
  ) dut (
    .i_sb_gck        (clk),
    .i_sb_rst        (rst),
    .i_sb_ctr        (ctr),
    .i_sb_run_instr  (run),
    .i_sb_dst_reg_vld(dvld),
    .i_sb_dst_reg    (dreg),
    .i_sb_sb_clr     (sb_clr),
    .o_sb_done       (done),
    .o_sb_reg_sb     (reg_sb),
    .o_sb_retire_cnt (cnt),
    .o_sb_rec_vld    (rec_vld),
    .i_sb_rec_rdy    (rec_rdy),
    .o_sb_rec_wr     (rec_wr),
    .o_sb_rec_reg    (rec_reg),
    .o_sb_rec_ovf    (ovf),
    .i_sb_ovf_clr    (ovf_clr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_idle();
    ctr     = 2'd0;
    run     = 1'b0;
    dvld    = 1'b0;
    dreg    = 4'd0;
    sb_clr  = 16'h0;
    rec_rdy = 1'b0;
    ovf_clr = 1'b0;
  endtask

  task automatic model_reset();
    mdl_q.delete();
    m_sb  = 16'h0;
    m_cnt = 4'd0;
    m_ovf = 1'b0;
    m_cap = 5'h0;
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".reg_sb"}, 32'(reg_sb), 32'(m_sb));
    chk({tag, ".cnt"}, 32'(cnt), 32'(m_cnt));
    chk({tag, ".rec_vld"}, 32'(rec_vld), 32'(mdl_q.size() != 0));
    chk({tag, ".ovf"}, 32'(ovf), 32'(m_ovf));
    if (mdl_q.size() != 0) chk({tag, ".head"}, 32'({rec_wr, rec_reg}), 32'(mdl_q[0]));
    else                   chk({tag, ".head_zero"}, 32'({rec_wr, rec_reg}), 32'h0);
  endtask

  // One full instruction slot; rdy3/oclr3 are asserted only on the last phase.
  task automatic run_slot(input logic r, input logic v, input logic [3:0] rg,
                          input logic [15:0] clr0, input logic rdy3, input logic oclr3);
    logic ovf_now;
    for (int ph = 0; ph < 4; ph++) begin
      ctr     = 2'(ph);
      run     = r;
      dvld    = v;
      dreg    = rg;
      sb_clr  = (ph == 0) ? clr0 : 16'h0;
      rec_rdy = (ph == 3) ? rdy3 : 1'b0;
      ovf_clr = (ph == 3) ? oclr3 : 1'b0;
      if (ph == 0) begin
        m_sb = (m_sb & ~clr0) | ((r && v) ? (16'h1 << rg) : 16'h0);
        if (r) m_cap = {v, rg};
      end
      if (ph == 3) begin
        ovf_now = 1'b0;
        if (rdy3 && mdl_q.size() != 0) begin
          chk("slot.pop_head", 32'({rec_wr, rec_reg}), 32'(mdl_q[0]));
          void'(mdl_q.pop_front());
        end
        if (r) begin
          m_cnt++;
          if (mdl_q.size() < DEPTH) mdl_q.push_back(m_cap);
          else ovf_now = 1'b1;
        end
        if (ovf_now) m_ovf = 1'b1;
        else if (oclr3) m_ovf = 1'b0;
      end
      tick();
      chk($sformatf("slot.done.ph%0d", ph), 32'(done), 32'(ph == 3 && r));
    end
    set_idle();
    check_state("slot");
  endtask

  task automatic idle_tick(input logic [15:0] clr, input logic oclr);
    set_idle();
    sb_clr  = clr;
    ovf_clr = oclr;
    m_sb    = m_sb & ~clr;
    if (oclr) m_ovf = 1'b0;
    tick();
    set_idle();
    check_state("idle");
  endtask

  task automatic pop_one();
    set_idle();
    chk("pop.vld", 32'(rec_vld), 32'h1);
    if (mdl_q.size() != 0) chk("pop.head", 32'({rec_wr, rec_reg}), 32'(mdl_q[0]));
    rec_rdy = 1'b1;
    tick();
    rec_rdy = 1'b0;
    if (mdl_q.size() != 0) void'(mdl_q.pop_front());
    check_state("pop");
  endtask

  initial begin
    t1[0] = '{1'b1, 1'b1, 4'd5, 16'h0020, 4'd1, 5'h15};
    t1[1] = '{1'b1, 1'b1, 4'd7, 16'h00A0, 4'd2, 5'h17};
    t1[2] = '{1'b1, 1'b1, 4'd5, 16'h00A0, 4'd3, 5'h15};
    t2[0] = '{1'b0, 1'b0, 4'd3, 16'h0000, 4'd0, 5'h00};
    t2[1] = '{1'b1, 1'b0, 4'd3, 16'h0000, 4'd0, 5'h03};
    t2[2] = '{1'b0, 1'b0, 4'd6, 16'h0000, 4'd0, 5'h00};
    t2[3] = '{1'b1, 1'b0, 4'd9, 16'h0000, 4'd0, 5'h09};

    set_idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    model_reset();
    chk("reset.done", 32'(done), 32'h0);
    check_state("reset");

    // Three writing slots, then drain in order.
    for (int i = 0; i < 3; i++) begin
      run_slot(t1[i].run, t1[i].vld, t1[i].rg, 16'h0, 1'b0, 1'b0);
      chk($sformatf("t1.sb%0d", i), 32'(reg_sb), 32'(t1[i].exp_sb));
      chk($sformatf("t1.cnt%0d", i), 32'(cnt), 32'(t1[i].exp_cnt));
    end
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t1.rec%0d", i), 32'({rec_wr, rec_reg}), 32'(t1[i].exp_rec));
      pop_one();
    end
    chk("t1.empty", 32'(rec_vld), 32'h0);

    // Set/clear collision on r5.
    idle_tick(16'hFFFF, 1'b0);
    chk("coll.pre", 32'(reg_sb), 32'h0);
    run_slot(1'b1, 1'b1, 4'd5, 16'h0020, 1'b0, 1'b0);
    chk("coll.set_wins", 32'(reg_sb), 32'h0020);
    idle_tick(16'h0020, 1'b0);
    chk("coll.cleared", 32'(reg_sb), 32'h0);
    pop_one();

    // Overflow with rec_rdy low.
    for (int i = 0; i < 8; i++) run_slot(1'b1, 1'b1, 4'(i), 16'h0, 1'b0, 1'b0);
    chk("ovf.vld8", 32'(rec_vld), 32'h1);
    chk("ovf.pre", 32'(ovf), 32'h0);
    run_slot(1'b1, 1'b1, 4'd8, 16'h0, 1'b0, 1'b0);
    chk("ovf.set", 32'(ovf), 32'h1);
    run_slot(1'b1, 1'b1, 4'd9, 16'h0, 1'b0, 1'b1);
    chk("ovf.clr_vs_set", 32'(ovf), 32'h1);
    idle_tick(16'h0, 1'b1);
    chk("ovf.cleared", 32'(ovf), 32'h0);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("ovf.drain%0d", i), 32'({rec_wr, rec_reg}), 32'({1'b1, 4'(i)}));
      pop_one();
    end
    chk("ovf.empty", 32'(rec_vld), 32'h0);

    // Full FIFO, pop coincides with the ninth push.
    for (int i = 0; i < 8; i++) run_slot(1'b1, 1'b1, 4'(8 + i), 16'h0, 1'b0, 1'b0);
    run_slot(1'b1, 1'b1, 4'd0, 16'h0, 1'b1, 1'b0);
    chk("full.no_ovf", 32'(ovf), 32'h0);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("full.drain%0d", i), 32'({rec_wr, rec_reg}), 32'({1'b1, 4'((9 + i) % 16)}));
      pop_one();
    end
    chk("full.empty", 32'(rec_vld), 32'h0);

    // Idle slots interleaved with non-writing run slots.
    idle_tick(16'hFFFF, 1'b0);
    for (int i = 0; i < 4; i++) begin
      run_slot(t2[i].run, t2[i].vld, t2[i].rg, 16'h0, 1'b0, 1'b0);
      chk($sformatf("t2.sb%0d", i), 32'(reg_sb), 32'(t2[i].exp_sb));
    end
    chk("t2.rec0", 32'({rec_wr, rec_reg}), 32'(t2[1].exp_rec));
    pop_one();
    chk("t2.rec1", 32'({rec_wr, rec_reg}), 32'(t2[3].exp_rec));
    pop_one();

    // Reset in the middle of a running slot with a full, overflowed FIFO.
    for (int i = 0; i < 9; i++) run_slot(1'b1, 1'b1, 4'(i), 16'h0, 1'b0, 1'b0);
    chk("rst.pre_ovf", 32'(ovf), 32'h1);
    run = 1'b1; dvld = 1'b1; dreg = 4'd2;
    ctr = 2'd0; tick();
    ctr = 2'd1; tick();
    rst = 1'b1;
    ctr = 2'd2; tick();
    ctr = 2'd3; tick();
    chk("rst.done_ph3", 32'(done), 32'h0);
    rst = 1'b0;
    set_idle();
    model_reset();
    tick();
    chk("rst.done", 32'(done), 32'h0);
    chk("rst.cnt", 32'(cnt), 32'h0);
    chk("rst.vld", 32'(rec_vld), 32'h0);
    chk("rst.ovf", 32'(ovf), 32'h0);
    check_state("rst");

    // Retire counter wrap at CNT_W=4.
    for (int i = 0; i < 15; i++) run_slot(1'b1, 1'b0, 4'(i), 16'h0, 1'b1, 1'b0);
    chk("wrap.cnt15", 32'(cnt), 32'd15);
    run_slot(1'b1, 1'b0, 4'd15, 16'h0, 1'b1, 1'b0);
    chk("wrap.cnt0", 32'(cnt), 32'd0);
    pop_one();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
